param_update: RTL and testbench
===============================

Name: param_update

Overview:
- Parameter store and serial update stage directly downstream of the backpropagation stage.
- Holds the network's current weights and biases and drives them to the feedforward and backprop stages.
- After a batch, on a start pulse, it snapshots the accumulated learning-rate-scaled dweight/dbias buses. It then applies p <= p - dp one parameter per cycle through a single shared saturating subtractor.
- When finished, it pulses a clear to the backprop accumulators.

Parameters:
N_IN, 2, hidden-layer inputs per perceptron
N_HL_P, 3, hidden-layer perceptrons
N_OUT, 2, output perceptrons
WIDTH, 32, fixed-point word width (signed)
FRAC, 24, fractional bits (documentation only; subtraction is format-agnostic)
localparam NP = N_HL_P*N_IN + N_HL_P + N_HL_P*N_OUT + N_OUT (17 by default); AW = $clog2(NP)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle pulse: begin update pass
i_wr_en  in  1  host write strobe (initial parameter load)
i_wr_addr  in  AW  flat parameter address
i_wr_data  in  WIDTH  parameter value to write
i_dbias_o  in  N_OUT*WIDTH  accumulated output-bias deltas
i_dbias_hd  in  N_HL_P*WIDTH  accumulated hidden-bias deltas
i_dwght_o  in  N_HL_P*N_OUT*WIDTH  accumulated output-weight deltas
i_dwght_hd  in  N_HL_P*N_IN*WIDTH  accumulated hidden-weight deltas
o_bias_o  out  N_OUT*WIDTH  current output biases
o_bias_hd  out  N_HL_P*WIDTH  current hidden biases
o_wght_o  out  N_HL_P*N_OUT*WIDTH  current output weights
o_wght_hd  out  N_HL_P*N_IN*WIDTH  current hidden weights
o_busy  out  1  update pass in progress
o_done  out  1  one-cycle pulse: pass complete
o_clr  out  1  one-cycle pulse to backprop accumulators (coincident with o_done)
o_epoch  out  16  completed-pass counter

Behaviour:
- Reset (rst=0, async): all parameters 0; FSM IDLE; o_busy/o_done/o_clr 0; o_epoch 0; index 0.
- Flat address map, each bus slice 0 at LSBs:
  - 0..N_HL_P*N_IN-1 = hidden weights
  - next N_HL_P = hidden biases
  - next N_HL_P*N_OUT = output weights
  - last N_OUT = output biases
- FSM states: IDLE, LOAD, UPDATE, DONE.
- IDLE:
  - i_wr_en with i_wr_addr < NP writes i_wr_data to that parameter next edge.
  - i_wr_addr >= NP is ignored.
  - i_start -> LOAD.
  - If i_start and i_wr_en coincide, start wins and the write is dropped.
- LOAD (1 cycle): snapshot all four delta buses into a shadow register; index <= 0; -> UPDATE. Delta inputs may change afterwards with no effect.
- UPDATE (NP cycles): each cycle p[idx] <= sat(p[idx] - d[idx]).
  - Compute the difference at WIDTH+1 bits.
  - Clamp to +2^(WIDTH-1)-1 / -2^(WIDTH-1).
  - idx increments; after idx = NP-1 -> DONE.
- DONE (1 cycle): o_done=1, o_clr=1, o_epoch increments (wraps 0xFFFF->0); -> IDLE.
- o_busy=1 in LOAD, UPDATE and DONE; 0 in IDLE.
- Latency: i_start at cycle 0 -> LOAD at 1 -> updates at 2..NP+1 -> o_done at NP+2 (19 with defaults). Next start is accepted from cycle NP+3.
- i_start or i_wr_en while busy: ignored, no queuing.
- Outputs always reflect the live parameter registers. During UPDATE, downstream stages see a partially updated set; they must not sample until o_done.
- Reset mid-pass aborts immediately: parameters 0, FSM IDLE, no o_done/o_clr.

Decomposition:
- Shared package:
  - address-region offset constants (HW_BASE, HB_BASE, OW_BASE, OB_BASE, NP) as functions of N_IN/N_HL_P/N_OUT
  - FSM state encoding
  - signed max/min constants for WIDTH
- One natural sub-module: sat_sub (WIDTH-parameterised combinational saturating subtractor), reusable by other update/accumulate stages.

Test Plan:
- Reset then idle -> all output buses 0, o_busy 0, o_epoch 0; write addr 17 (>=NP) -> no parameter changes.
- Write every address with 0x01000000 (1.0), deltas all 0x00400000 (0.25), pulse start -> o_done exactly 19 cycles later with o_clr; every parameter 0x00C00000; o_epoch 1.
- Parameter 0x7FFFFFF0, delta 0x80000000 (most negative) -> result saturates at 0x7FFFFFFF. Parameter 0x80000010, delta 0x00000100 -> result 0x80000000.
- Change delta inputs to random values one cycle after start, and pulse start plus write mid-pass -> results use the LOAD-cycle snapshot only; the extra start and the write are ignored; a single o_done.
- Start and write in the same IDLE cycle -> pass runs, written parameter unchanged by the write.
- Assert rst at cycle 8 of a pass -> all outputs 0 immediately, o_done never pulses, o_epoch stays 0. A subsequent normal pass completes correctly.

Source files
------------

// File: rtl/param_update_pkg.sv
// Shared definitions for the parameter store: flat address map, FSM encoding.
package param_update_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned HW_BASE = 0;

    function automatic int unsigned hb_base_of(input int unsigned n_in, input int unsigned n_hl);
        return n_hl * n_in;
    endfunction

    function automatic int unsigned ow_base_of(input int unsigned n_in, input int unsigned n_hl);
        return hb_base_of(n_in, n_hl) + n_hl;
    endfunction

    function automatic int unsigned ob_base_of(input int unsigned n_in, input int unsigned n_hl,
                                               input int unsigned n_out);
        return ow_base_of(n_in, n_hl) + n_hl * n_out;
    endfunction

    function automatic int unsigned np_of(input int unsigned n_in, input int unsigned n_hl,
                                          input int unsigned n_out);
        return ob_base_of(n_in, n_hl, n_out) + n_out;
    endfunction

endpackage

// File: rtl/sat_sub.sv
// Combinational signed saturating subtractor: y = clamp(a - b) to WIDTH bits.
module sat_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y_c
);

    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] diff;

    always_comb begin
        diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        // Top two bits disagree only when the result left the WIDTH-bit range.
        if (diff[WIDTH] != diff[WIDTH-1]) begin
            y_c = diff[WIDTH] ? S_MIN : S_MAX;
        end else begin
            y_c = diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/param_update.sv
// Weight/bias store with a serial, one-parameter-per-cycle saturating update pass.
module param_update
    import param_update_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_HL_P = 3,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned FRAC   = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic                            i_wr_en,
    input  logic [$clog2(np_of(N_IN, N_HL_P, N_OUT))-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]                i_wr_data,
    input  logic [N_OUT*WIDTH-1:0]          i_dbias_o,
    input  logic [N_HL_P*WIDTH-1:0]         i_dbias_hd,
    input  logic [N_HL_P*N_OUT*WIDTH-1:0]   i_dwght_o,
    input  logic [N_HL_P*N_IN*WIDTH-1:0]    i_dwght_hd,
    output logic [N_OUT*WIDTH-1:0]          o_bias_o,
    output logic [N_HL_P*WIDTH-1:0]         o_bias_hd,
    output logic [N_HL_P*N_OUT*WIDTH-1:0]   o_wght_o,
    output logic [N_HL_P*N_IN*WIDTH-1:0]    o_wght_hd,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_clr,
    output logic [15:0]                     o_epoch
);

    localparam int unsigned NP      = np_of(N_IN, N_HL_P, N_OUT);
    localparam int unsigned AW      = $clog2(NP);
    localparam int unsigned HB_BASE = hb_base_of(N_IN, N_HL_P);
    localparam int unsigned OW_BASE = ow_base_of(N_IN, N_HL_P);
    localparam int unsigned OB_BASE = ob_base_of(N_IN, N_HL_P, N_OUT);

    if (FRAC >= WIDTH) begin : g_frac_check
        $error("FRAC must be smaller than WIDTH");
    end

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] param_q [NP];
    logic [WIDTH-1:0] param_d [NP];
    logic [WIDTH-1:0] delta_q [NP];
    logic [WIDTH-1:0] delta_d [NP];
    logic [15:0]      epoch_q, epoch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [NP*WIDTH-1:0] flat_d;
    logic [NP*WIDTH-1:0] flat_p;
    logic [WIDTH-1:0]    sub_y;
    logic                wr_ok;

    // Delta buses concatenated in flat-address order (hidden weights at LSBs).
    assign flat_d = {i_dbias_o, i_dwght_o, i_dbias_hd, i_dwght_hd};
    assign wr_ok  = i_wr_en && ({1'b0, i_wr_addr} < (AW+1)'(NP));

    sat_sub #(.WIDTH(WIDTH)) u_sat_sub (
        .a   (param_q[idx_q]),
        .b   (delta_q[idx_q]),
        .y_c (sub_y)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        param_d = param_q;
        delta_d = delta_q;
        epoch_d = epoch_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                end else if (wr_ok) begin
                    param_d[i_wr_addr] = i_wr_data;
                end
            end
            ST_LOAD: begin
                for (int k = 0; k < NP; k++) begin
                    delta_d[k] = flat_d[k*WIDTH +: WIDTH];
                end
                idx_d   = '0;
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                param_d[idx_q] = sub_y;
                if (idx_q == AW'(NP-1)) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                    epoch_d = epoch_q + 16'd1;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            param_q <= '{default: '0};
            delta_q <= '{default: '0};
            epoch_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            param_q <= param_d;
            delta_q <= delta_d;
            epoch_q <= epoch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NP; k++) begin
            flat_p[k*WIDTH +: WIDTH] = param_q[k];
        end
    end

    assign o_wght_hd = flat_p[HW_BASE*WIDTH +: N_HL_P*N_IN*WIDTH];
    assign o_bias_hd = flat_p[HB_BASE*WIDTH +: N_HL_P*WIDTH];
    assign o_wght_o  = flat_p[OW_BASE*WIDTH +: N_HL_P*N_OUT*WIDTH];
    assign o_bias_o  = flat_p[OB_BASE*WIDTH +: N_OUT*WIDTH];
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_clr     = done_q;
    assign o_epoch   = epoch_q;

endmodule

// File: tb/tb_param_update.sv
// Directed/randomized bench for param_update against a flat-array reference model.
module tb_param_update;

    localparam int NP = 17;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_start, i_wr_en;
    logic [4:0]      i_wr_addr;
    logic [W-1:0]    i_wr_data;
    logic [2*W-1:0]  i_dbias_o;
    logic [3*W-1:0]  i_dbias_hd;
    logic [6*W-1:0]  i_dwght_o;
    logic [6*W-1:0]  i_dwght_hd;
    logic [2*W-1:0]  o_bias_o;
    logic [3*W-1:0]  o_bias_hd;
    logic [6*W-1:0]  o_wght_o;
    logic [6*W-1:0]  o_wght_hd;
    logic            o_busy, o_done, o_clr;
    logic [15:0]     o_epoch;

    logic [W-1:0] p_m  [NP];
    logic [W-1:0] d_in [NP];
    logic [15:0]  epoch_m;
    int errors = 0;
    int checks = 0;

    param_update dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_wr_en(i_wr_en),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_dbias_o(i_dbias_o), .i_dbias_hd(i_dbias_hd),
        .i_dwght_o(i_dwght_o), .i_dwght_hd(i_dwght_hd),
        .o_bias_o(o_bias_o), .o_bias_hd(o_bias_hd),
        .o_wght_o(o_wght_o), .o_wght_hd(o_wght_hd),
        .o_busy(o_busy), .o_done(o_done), .o_clr(o_clr), .o_epoch(o_epoch)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] sat(input logic [W-1:0] a, input logic [W-1:0] b);
        longint r;
        r = longint'($signed(a)) - longint'($signed(b));
        if (r > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (r < -64'sd2147483648) return 32'h8000_0000;
        return r[31:0];
    endfunction

    function automatic logic [W-1:0] get_param(input int k);
        if (k < 6)  return o_wght_hd[k*W +: W];
        if (k < 9)  return o_bias_hd[(k-6)*W +: W];
        if (k < 15) return o_wght_o[(k-9)*W +: W];
        return o_bias_o[(k-15)*W +: W];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_params(input string tag);
        for (int k = 0; k < NP; k++)
            check($sformatf("%s_p%0d", tag, k), get_param(k), p_m[k]);
    endtask

    task automatic drive_deltas();
        for (int k = 0; k < NP; k++) begin
            if (k < 6)       i_dwght_hd[k*W +: W]     = d_in[k];
            else if (k < 9)  i_dbias_hd[(k-6)*W +: W] = d_in[k];
            else if (k < 15) i_dwght_o[(k-9)*W +: W]  = d_in[k];
            else             i_dbias_o[(k-15)*W +: W] = d_in[k];
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [W-1:0] data);
        i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = data;
        @(negedge clk);
        i_wr_en = 1'b0;
        if (int'(addr) < NP) p_m[addr] = data;
    endtask

    // Start a pass at a negedge; deltas present in the LOAD cycle are the model's snapshot.
    task automatic run_pass(input string tag, input bit co_wr, input bit disturb);
        logic [W-1:0] snap [NP];
        int lat, dones;
        bit clr_ok;
        lat = 0; dones = 0; clr_ok = 1'b0;
        i_start = 1'b1;
        if (co_wr) begin i_wr_en = 1'b1; i_wr_addr = 5'd3; i_wr_data = 32'hDEAD_BEEF; end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            i_start = 1'b0; i_wr_en = 1'b0;
            if (cyc == 1) begin
                snap = d_in;
                check({tag, "_busy_load"}, 32'(o_busy), 32'd1);
            end
            if (o_done) begin
                dones++;
                if (lat == 0) begin lat = cyc; clr_ok = o_clr; end
            end
            if (disturb && cyc >= 2 && cyc < 20) begin
                for (int k = 0; k < NP; k++) d_in[k] = $urandom;
                drive_deltas();
            end
            if (disturb && cyc == 8) begin
                i_start = 1'b1; i_wr_en = 1'b1; i_wr_addr = 5'd5; i_wr_data = $urandom;
            end
        end
        for (int k = 0; k < NP; k++) p_m[k] = sat(p_m[k], snap[k]);
        epoch_m = epoch_m + 16'd1;
        check({tag, "_latency"}, 32'(lat), 32'd19);
        check({tag, "_done_count"}, 32'(dones), 32'd1);
        check({tag, "_clr_with_done"}, 32'(clr_ok), 32'd1);
        check({tag, "_busy_end"}, 32'(o_busy), 32'd0);
        check({tag, "_epoch"}, 32'(o_epoch), 32'(epoch_m));
        check_params(tag);
    endtask

    initial begin
        rst = 1'b0; i_start = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        i_dbias_o = '0; i_dbias_hd = '0; i_dwght_o = '0; i_dwght_hd = '0;
        p_m = '{default: '0}; d_in = '{default: '0}; epoch_m = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        check_params("reset");
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_done", 32'(o_done), 32'd0);
        check("reset_clr", 32'(o_clr), 32'd0);
        check("reset_epoch", 32'(o_epoch), 32'd0);

        // Out-of-range write ignored
        wr(5'd17, 32'h1234_5678);
        wr(5'd31, 32'h1234_5678);
        check_params("oob_write");

        // Uniform 1.0 - 0.25
        for (int k = 0; k < NP; k++) begin
            wr(5'(k), 32'h0100_0000);
            d_in[k] = 32'h0040_0000;
        end
        drive_deltas();
        check_params("load_all");
        run_pass("uniform", 1'b0, 1'b0);
        for (int k = 0; k < NP; k++)
            check($sformatf("uniform_const_p%0d", k), get_param(k), 32'h00C0_0000);

        // Saturation corners, random elsewhere
        for (int k = 0; k < NP; k++) begin
            wr(5'(k), $urandom);
            d_in[k] = $urandom;
        end
        wr(5'd0, 32'h7FFF_FFF0); d_in[0] = 32'h8000_0000;
        wr(5'd1, 32'h8000_0010); d_in[1] = 32'h0000_0100;
        drive_deltas();
        run_pass("sat", 1'b0, 1'b0);
        check("sat_pos", get_param(0), 32'h7FFF_FFFF);
        check("sat_neg", get_param(1), 32'h8000_0000);

        // Snapshot isolation plus ignored start/write mid-pass
        for (int k = 0; k < NP; k++) d_in[k] = $urandom;
        drive_deltas();
        run_pass("snapshot", 1'b0, 1'b1);

        // Start and write in the same idle cycle
        for (int k = 0; k < NP; k++) d_in[k] = $urandom_range(0, 32'h00FF_FFFF);
        drive_deltas();
        run_pass("start_wr", 1'b1, 1'b0);

        // Reset in the middle of a pass
        i_start = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        rst = 1'b0;
        #1;
        p_m = '{default: '0}; epoch_m = '0;
        check_params("abort");
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_epoch", 32'(o_epoch), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (25) begin
                @(negedge clk);
                if (o_done || o_clr) seen++;
            end
            check("abort_no_done", 32'(seen), 32'd0);
            check("abort_epoch_hold", 32'(o_epoch), 32'd0);
        end

        // Normal pass after the abort
        for (int k = 0; k < NP; k++) begin
            wr(5'(k), $urandom);
            d_in[k] = $urandom;
        end
        drive_deltas();
        run_pass("post_abort", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
